// File: rtl/sequencer_pkg.sv
// Shared state encoding and instruction-class constants for the datapath sequencer.
package sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      EXEC  = 3'd2,
      MEM   = 3'd3,
      HALT  = 3'd4
   } state_t;

   localparam logic [2:0] CLS_ALU   = 3'd0;
   localparam logic [2:0] CLS_COND  = 3'd1;
   localparam logic [2:0] CLS_LOAD  = 3'd2;
   localparam logic [2:0] CLS_STORE = 3'd3;
   localparam logic [2:0] CLS_JUMP  = 3'd4;
   localparam logic [2:0] CLS_HALT  = 3'd5;

   localparam int CLS_MSB = 31;
   localparam int CLS_LSB = 29;

   function automatic logic [2:0] get_cls(input logic [31:0] word);
      return word[CLS_MSB:CLS_LSB];
   endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Data-port watchdog: counts cycles without an ack and flags the cycle
// in which the count would reach TIMEOUT.
module mem_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_count;

   // Expiry is combinational so the abort happens in the cycle the limit is hit.
   assign o_expired = i_en && (r_count == LIMIT);

   // Wait-cycle counter, cleared at the start of every data access.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= {CW{1'b0}};
      end else if (i_clear) begin
         r_count <= {CW{1'b0}};
      end else if (i_en && !o_expired) begin
         r_count <= r_count + CW'(1);
      end else begin
         r_count <= r_count;
      end
   end

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the datapath: fetch, execute, load/store with
// watchdog, and a retired-instruction counter.
module datapath_sequencer
   import sequencer_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [31:0]      program_counter,
   output logic [31:0]      imem_addr,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [31:0]      imem_data,
   output logic [31:0]      instr_q,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   output logic             pc_inc,
   output logic             write_en,
   output logic             ld,
   output logic             jump,
   output logic             busy,
   output logic             halted,
   output logic             err_illegal,
   output logic             err_timeout,
   output logic [CNT_W-1:0] retired_count
);

   state_t           r_state;
   state_t           w_next_state;
   logic [31:0]      r_instr;
   logic [CNT_W-1:0] r_retired;
   logic [2:0]       w_cls;
   logic             w_retire;
   logic             w_wd_clear;
   logic             w_wd_en;
   logic             w_expired;

   assign w_cls         = get_cls(r_instr);
   assign instr_q       = r_instr;
   assign retired_count = r_retired;
   assign imem_addr     = imem_req ? program_counter : 32'd0;
   assign w_wd_en       = (r_state == MEM) && !dmem_ack;

   mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_clear   (w_wd_clear),
      .i_en      (w_wd_en),
      .o_expired (w_expired)
   );

   // State, instruction latch and retire counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_instr   <= 32'd0;
         r_retired <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_next_state;
         if ((r_state == FETCH) && imem_ack) begin
            r_instr <= imem_data;
         end else begin
            r_instr <= r_instr;
         end
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end else begin
            r_retired <= r_retired;
         end
      end
   end

   // Next state and strobes; MEM terms are qualified by the data ack.
   always_comb begin
      w_next_state = r_state;
      w_retire     = 1'b0;
      w_wd_clear   = 1'b0;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      pc_inc       = 1'b0;
      write_en     = 1'b0;
      ld           = 1'b0;
      jump         = 1'b0;
      busy         = 1'b1;
      halted       = 1'b0;
      err_illegal  = 1'b0;
      err_timeout  = 1'b0;
      case (r_state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               w_next_state = FETCH;
            end else begin
               w_next_state = IDLE;
            end
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               w_next_state = EXEC;
            end else begin
               w_next_state = FETCH;
            end
         end
         EXEC: begin
            w_next_state = FETCH;
            case (w_cls)
               CLS_ALU, CLS_COND: begin
                  write_en = 1'b1;
                  pc_inc   = 1'b1;
                  w_retire = 1'b1;
               end
               CLS_JUMP: begin
                  write_en = 1'b1;
                  jump     = 1'b1;
                  w_retire = 1'b1;
               end
               CLS_LOAD, CLS_STORE: begin
                  w_wd_clear   = 1'b1;
                  w_next_state = MEM;
               end
               CLS_HALT: begin
                  pc_inc       = 1'b1;
                  w_retire     = 1'b1;
                  w_next_state = HALT;
               end
               default: begin
                  pc_inc      = 1'b1;
                  err_illegal = 1'b1;
               end
            endcase
         end
         MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (w_cls == CLS_STORE);
            if (dmem_ack) begin
               pc_inc       = 1'b1;
               ld           = (w_cls == CLS_LOAD);
               write_en     = (w_cls == CLS_LOAD);
               w_retire     = 1'b1;
               w_next_state = FETCH;
            end else if (w_expired) begin
               pc_inc       = 1'b1;
               err_timeout  = 1'b1;
               w_next_state = FETCH;
            end else begin
               w_next_state = MEM;
            end
         end
         HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
            if (start) begin
               w_next_state = FETCH;
            end else begin
               w_next_state = HALT;
            end
         end
         default: begin
            busy         = 1'b0;
            w_next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized self-checking bench: each instruction is scored against counts
// and latencies derived from the instruction class and the ack delays.
module tb_datapath_sequencer;

   localparam int TO = 6;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [31:0] program_counter;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_data;
   logic [31:0] instr_q;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        pc_inc;
   logic        write_en;
   logic        ld;
   logic        jump;
   logic        busy;
   logic        halted;
   logic        err_illegal;
   logic        err_timeout;
   logic [31:0] retired_count;

   int checks = 0;
   int errors = 0;
   int exp_retired = 0;
   bit have_edge = 0;

   datapath_sequencer #(.TIMEOUT(TO), .CNT_W(32)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .program_counter (program_counter),
      .imem_addr       (imem_addr),
      .imem_req        (imem_req),
      .imem_ack        (imem_ack),
      .imem_data       (imem_data),
      .instr_q         (instr_q),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_ack        (dmem_ack),
      .pc_inc          (pc_inc),
      .write_en        (write_en),
      .ld              (ld),
      .jump            (jump),
      .busy            (busy),
      .halted          (halted),
      .err_illegal     (err_illegal),
      .err_timeout     (err_timeout),
      .retired_count   (retired_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next_edge();
      if (have_edge) have_edge = 0;
      else @(negedge clk);
   endtask

   // Drive one instruction: fetch ack after fd wait cycles, data ack after md wait cycles.
   task automatic run_instr(input logic [31:0] word, input int fd, input int md);
      logic [2:0] c;
      bit is_mem, acked, done, fetched;
      int mem, cyc, fetch_cnt, mem_cnt;
      int n_pc, n_we, n_ld, n_jump, n_ill, n_to, n_dreq, n_dwe, n_busy, addr_bad, ld_bad;
      int e_we;
      bit e_retire;
      c = word[31:29];
      is_mem = (c == 3'd2) || (c == 3'd3);
      acked = (md < TO);
      mem = is_mem ? (acked ? md + 1 : TO) : 0;
      e_we = (c == 3'd0 || c == 3'd1 || c == 3'd4 || (c == 3'd2 && acked)) ? 1 : 0;
      e_retire = (c <= 3'd5) && !(is_mem && !acked);
      if (e_retire) exp_retired++;
      done = 0; fetched = 0; cyc = 0; fetch_cnt = 0; mem_cnt = 0;
      n_pc = 0; n_we = 0; n_ld = 0; n_jump = 0; n_ill = 0; n_to = 0;
      n_dreq = 0; n_dwe = 0; n_busy = 0; addr_bad = 0; ld_bad = 0;
      for (int k = 0; k < 400 && !done; k++) begin
         next_edge();
         if (fetched && (imem_req || halted)) begin
            have_edge = 1;
            done = 1;
         end else begin
            cyc++;
            program_counter = $urandom;
            start = 1'($urandom_range(0, 1));
            if (imem_req) begin
               imem_ack  = (fetch_cnt == fd);
               imem_data = (fetch_cnt == fd) ? word : $urandom;
               if (fetch_cnt == fd) fetched = 1;
               fetch_cnt++;
            end else begin
               imem_ack  = 1'($urandom_range(0, 1));
               imem_data = $urandom;
            end
            if (dmem_req) begin
               dmem_ack = (mem_cnt == md);
               mem_cnt++;
            end else begin
               dmem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            if (imem_req && imem_addr !== program_counter) addr_bad++;
            if (ld && !dmem_ack) ld_bad++;
            n_pc   += int'(pc_inc);
            n_we   += int'(write_en);
            n_ld   += int'(ld);
            n_jump += int'(jump);
            n_ill  += int'(err_illegal);
            n_to   += int'(err_timeout);
            n_dreq += int'(dmem_req);
            n_dwe  += int'(dmem_req & dmem_we);
            n_busy += int'(busy);
         end
      end
      check_val("instr_done", 32'(done), 32'd1);
      check_val("cycles", cyc, fd + 2 + mem);
      check_val("pc_inc", n_pc, (c == 3'd4) ? 0 : 1);
      check_val("write_en", n_we, e_we);
      check_val("ld", n_ld, (c == 3'd2 && acked) ? 1 : 0);
      check_val("ld_no_ack", ld_bad, 0);
      check_val("jump", n_jump, (c == 3'd4) ? 1 : 0);
      check_val("err_illegal", n_ill, (c >= 3'd6) ? 1 : 0);
      check_val("err_timeout", n_to, (is_mem && !acked) ? 1 : 0);
      check_val("dmem_req", n_dreq, mem);
      check_val("dmem_we", n_dwe, (c == 3'd3) ? mem : 0);
      check_val("busy", n_busy, cyc);
      check_val("imem_addr", addr_bad, 0);
      check_val("instr_q", instr_q, word);
      check_val("retired", retired_count, exp_retired);
   endtask

   task automatic run_random(input int n);
      logic [2:0] c;
      for (int i = 0; i < n; i++) begin
         c = 3'($urandom_range(0, 6));
         if (c >= 3'd5) c = c + 3'd1;
         run_instr({c, 29'($urandom)}, $urandom_range(0, 3), $urandom_range(0, TO + 1));
      end
   endtask

   initial begin
      int bad;
      reset_n = 1'b0; start = 1'b0; program_counter = 32'd0;
      imem_ack = 1'b0; imem_data = 32'd0; dmem_ack = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check_val("rst_instr_q", instr_q, 32'd0);
      check_val("rst_retired", retired_count, 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_reqs", {30'd0, imem_req, dmem_req}, 32'd0);
      check_val("rst_strobes", {28'd0, pc_inc, write_en, ld, jump}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      have_edge = 1;

      // Three back-to-back ALU words with immediate fetch acks.
      for (int i = 0; i < 3; i++) run_instr(32'h0000_0000, 0, 0);
      check_val("retired_3", retired_count, 32'd3);
      run_instr(32'h4000_0000, 0, 4);
      run_instr(32'h4000_0000, 1, TO - 1);
      run_instr(32'h6000_0000, 1, TO + 3);
      run_instr(32'h6000_0000, 0, TO - 1);
      run_instr(32'hC000_0000, 0, 0);
      run_instr(32'hE123_4567, 2, 0);
      run_instr(32'h8000_0001, 0, 0);
      run_random(40);

      run_instr(32'hA000_0000, 1, 0);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         next_edge();
         start = 1'b0;
         imem_ack = 1'($urandom_range(0, 1));
         dmem_ack = 1'($urandom_range(0, 1));
         #1;
         if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || dmem_req !== 1'b0) bad++;
      end
      check_val("halt_stable", bad, 0);
      @(negedge clk);
      start = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
      @(negedge clk);
      start = 1'b0;
      #1;
      check_val("resume_req", {30'd0, imem_req, halted}, 32'd2);
      have_edge = 1;
      run_random(10);

      // Reset while a load waits in MEM; a late ack must be ignored.
      next_edge();
      start = 1'b0; imem_ack = 1'b1; imem_data = 32'h4000_0000; dmem_ack = 1'b0;
      @(negedge clk);
      imem_ack = 1'b0;
      @(negedge clk);
      #1;
      check_val("mem_req_before_rst", 32'(dmem_req), 32'd1);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check_val("async_drop", {30'd0, dmem_req, busy}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      dmem_ack = 1'b1;
      imem_ack = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_val("post_rst_idle", {29'd0, dmem_req, imem_req, busy}, 32'd0);
      check_val("post_rst_retired", retired_count, 32'd0);
      check_val("post_rst_instr_q", instr_q, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
- Multi-cycle control FSM that drives the `datapath` block.
- Fetches instruction words over a req/ack instruction port and holds the current word for the field decoder.
- Generates per-instruction strobes for the datapath: `pc_inc`, `write_en` (AND-ed externally with the datapath `write` field), `ld` and `jump`.
- Runs load/store transactions on a req/ack data port, with a watchdog timeout and a retired-instruction counter.

Parameters:
- TIMEOUT, 255: maximum cycles spent waiting for `dmem_ack` before the access is aborted.
- CNT_W, 32: width of `retired_count`.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE or HALT.
- program_counter  in  32  datapath r0 value.
- imem_addr  out  32  instruction address; equals `program_counter` while `imem_req`=1.
- imem_req  out  1  fetch request.
- imem_ack  in  1  fetch complete; `imem_data` is valid in the same cycle.
- imem_data  in  32  instruction word.
- instr_q  out  32  latched current instruction, to the field decoder.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while `dmem_req`=1.
- dmem_ack  in  1  data access complete; load data is valid on the datapath `ld_data` input in the same cycle.
- pc_inc  out  1  datapath PC increment strobe.
- write_en  out  1  register write enable strobe.
- ld  out  1  selects `ld_data` into datapath C.
- jump  out  1  datapath r0-visible select.
- busy  out  1  high when not in IDLE or HALT.
- halted  out  1  high in HALT.
- err_illegal  out  1  one-cycle pulse on a reserved instruction class.
- err_timeout  out  1  one-cycle pulse on a data-port timeout.
- retired_count  out  CNT_W  number of completed instructions; wraps.

Behaviour:
- Reset: state=IDLE, `instr_q`=0, `retired_count`=0, watchdog=0, all strobes and requests 0. Asserting reset mid-transaction drops `imem_req`/`dmem_req` immediately; a later ack is ignored.
- Instruction class = `instr_q[31:29]`:
  - 0 ALU
  - 1 COND
  - 2 LOAD
  - 3 STORE
  - 4 JUMP
  - 5 HALT
  - 6–7 reserved
- All strobe outputs are decoded combinationally from state (Moore, plus ack-qualified terms in MEM).
- IDLE:
  - `start`=1 -> FETCH.
  - `start` is ignored in every other state except HALT.
- FETCH:
  - `imem_req`=1 and held until ack.
  - On `imem_ack`: `instr_q` <= `imem_data`, -> EXEC.
  - No timeout on the instruction port.
- EXEC (exactly one cycle):
  - ALU, COND: `write_en`=1, `pc_inc`=1, retire, -> FETCH.
  - JUMP: `write_en`=1, `jump`=1, `pc_inc`=0, retire, -> FETCH.
  - LOAD, STORE: no strobes, watchdog cleared, -> MEM.
  - HALT: `pc_inc`=1, retire, -> HALT.
  - Reserved: `pc_inc`=1, `err_illegal`=1, not retired, -> FETCH.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for STORE.
  - Each cycle without `dmem_ack` increments the watchdog.
  - On `dmem_ack`:
    - LOAD: `ld`=1, `write_en`=1, `pc_inc`=1.
    - STORE: `pc_inc`=1 only.
    - Then retire, -> FETCH.
  - If the watchdog reaches TIMEOUT with no ack: `err_timeout`=1, `pc_inc`=1, no write, not retired, -> FETCH.
  - If `dmem_ack` arrives in the same cycle the watchdog reaches TIMEOUT, the ack wins.
- HALT:
  - `halted`=1.
  - `start`=1 -> FETCH, resuming at the current `program_counter`.
- Retire: `retired_count` += 1, modulo 2^CNT_W.
- Acks presented while their request is 0 are ignored.
- Back-to-back fetch: an ack in the first FETCH cycle gives 2 cycles per ALU instruction.
- `pc_inc` is asserted at most once per instruction.

Decomposition:
- Shared package `sequencer_pkg` holds:
  - state enum {IDLE, FETCH, EXEC, MEM, HALT};
  - class constants CLS_ALU=0 … CLS_HALT=5;
  - class field position 31:29.
- One sub-module, `mem_watchdog`: clear/enable/count with a TIMEOUT compare, output `expired`.

Test Plan:
- Reset, `start`=1, `imem_ack` each cycle, words 0x0000_0000 x3 -> `pc_inc`/`write_en` pulse on cycles 2, 4, 6 after start; `retired_count`=3.
- LOAD word 0x4000_0000, `dmem_ack` 5 cycles after MEM entry -> `dmem_req` high 5 cycles, `dmem_we`=0; `ld`, `write_en` and `pc_inc` high only in the ack cycle.
- STORE 0x6000_0000 with TIMEOUT=4 and no ack -> `err_timeout` pulses on the 4th MEM cycle, `write_en` stays 0, `retired_count` unchanged, FSM back in FETCH.
- Word 0xC000_0000 -> `err_illegal` single pulse, `pc_inc`=1, no `write_en`; next fetch proceeds.
- HALT 0xA000_0000 -> `halted`=1, `busy`=0 and stable for 20 cycles; `start` pulse -> FETCH with `imem_req`=1 next cycle.
- `reset_n` pulled low during MEM with `dmem_req`=1 -> `dmem_req` drops asynchronously; a late `dmem_ack` after release is ignored; state IDLE, `retired_count`=0.
